mpc_dot_accum: RTL and testbench

Downstream consumer of the 21s x 14ns -> 36-bit pipelined multiplier in the implicit-MPC datapath. It accumulates a stream of signed products that form one dot product (one row of H*u or F*x), then rounds, rescales and saturates the sum back to the 21-bit signed working format. The result is presented on a single-entry valid/ready output register. It shares the multiplier's ce so the whole row pipeline stalls as one unit.

---
 rtl/mpc_pkg.sv | 36 +++
 rtl/mpc_round_sat.sv | 37 +++
 rtl/mpc_dot_accum.sv | 92 +++++++++
 tb/tb_mpc_dot_accum.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_pkg.sv
// Shared MPC datapath constants and the round/saturate helper used by the row stages.
package mpc_pkg;

   localparam int unsigned PROD_W    = 36;
   localparam int unsigned ACC_W     = 44;
   localparam int unsigned DATA_W    = 21;
   localparam int unsigned FRAC_W    = 14;
   localparam int unsigned MAX_TERMS = 256;
   localparam int unsigned CNT_W     = 9;

   // Width of the rescaled sum before clipping to DATA_W.
   localparam int unsigned RND_W     = ACC_W + 1 - FRAC_W;

   typedef struct packed {
      logic              sat;
      logic [DATA_W-1:0] data;
   } sat_data_t;

   // Round half-up toward +inf, drop FRAC_W fraction bits, clip to DATA_W signed.
   function automatic sat_data_t sat_round(input logic [ACC_W:0] sum);
      logic [ACC_W:0]   biased;
      logic [RND_W-1:0] r;
      sat_data_t        res;
      biased   = sum + ((ACC_W+1)'(1) << (FRAC_W - 1));
      r        = biased[ACC_W:FRAC_W];
      res.sat  = 1'b0;
      res.data = r[DATA_W-1:0];
      if (r[RND_W-1:DATA_W-1] != {(RND_W-DATA_W+1){r[RND_W-1]}}) begin
         res.sat  = 1'b1;
         res.data = r[RND_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
      end
      return res;
   endfunction

endpackage

// File: rtl/mpc_round_sat.sv
// Combinational round-half-up, arithmetic rescale and signed saturation of a dot-product sum.
module mpc_round_sat
   import mpc_pkg::*;
#(
   parameter int unsigned ACC_WIDTH  = ACC_W,
   parameter int unsigned OUT_WIDTH  = DATA_W,
   parameter int unsigned FRAC_SHIFT = FRAC_W
) (
   input  logic [ACC_WIDTH:0]   sum,
   output logic [OUT_WIDTH-1:0] data,
   output logic                 sat
);

   localparam int unsigned R_W  = ACC_WIDTH + 1 - FRAC_SHIFT;
   localparam int unsigned HI_W = R_W - OUT_WIDTH + 1;
   localparam logic [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (FRAC_SHIFT - 1);

   logic [ACC_WIDTH:0] biased;
   logic [R_W-1:0]     r;
   logic               ovf;

   // One extra bit of headroom keeps the bias add from wrapping.
   assign biased = sum + HALF;
   assign r      = biased[ACC_WIDTH:FRAC_SHIFT];
   assign ovf    = (r[R_W-1:OUT_WIDTH-1] != {HI_W{r[R_W-1]}});

   always_comb begin
      data = r[OUT_WIDTH-1:0];
      sat  = 1'b0;
      if (ovf) begin
         sat  = 1'b1;
         data = r[R_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                         : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/mpc_dot_accum.sv
// Dot-product accumulator: sums a product stream, then rounds/saturates into a
// single-entry valid/ready result register. Shares ce with the upstream multiplier.
module mpc_dot_accum
   import mpc_pkg::*;
#(
   parameter int unsigned PROD_WIDTH = PROD_W,
   parameter int unsigned ACC_WIDTH  = ACC_W,
   parameter int unsigned OUT_WIDTH  = DATA_W,
   parameter int unsigned FRAC_SHIFT = FRAC_W,
   parameter int unsigned MAX_TERMS  = mpc_pkg::MAX_TERMS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic                  in_last,
   input  logic [PROD_WIDTH-1:0] in_prod,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_sat,
   output logic [8:0]            out_count,
   output logic                  err_terms
);

   localparam int unsigned GUARD_W = ACC_WIDTH - PROD_WIDTH;

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] sum;
   logic [8:0]           term_cnt;
   logic                 acc_fire;
   logic                 out_fire;
   logic                 load;
   logic [OUT_WIDTH-1:0] rs_data;
   logic                 rs_sat;

   // Ready is combinational so a drain and a new last beat can share a cycle.
   assign in_ready = ce & (~out_valid | out_ready);
   assign acc_fire = in_valid & in_ready;
   assign out_fire = ce & out_valid & out_ready;
   assign load     = acc_fire & in_last;
   assign sum      = acc + {{GUARD_W{in_prod[PROD_WIDTH-1]}}, in_prod};

   mpc_round_sat #(
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) u_round_sat (
      .sum  ({sum[ACC_WIDTH-1], sum}),
      .data (rs_data),
      .sat  (rs_sat)
   );

   // Accumulator and term counter; a last beat restarts the next vector from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc       <= '0;
         term_cnt  <= '0;
         err_terms <= 1'b0;
      end else if (acc_fire) begin
         if (in_last) begin
            acc      <= '0;
            term_cnt <= '0;
         end else begin
            acc      <= sum;
            term_cnt <= term_cnt + 9'd1;
         end
         if (term_cnt == 9'(MAX_TERMS)) begin
            err_terms <= 1'b1;
         end
      end
   end

   // Result register; a load overrides a simultaneous drain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_count <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= rs_data;
         out_sat   <= rs_sat;
         out_count <= term_cnt + 9'd1;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mpc_dot_accum.sv
// Directed self-checking bench for mpc_dot_accum.
module tb_mpc_dot_accum;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic        in_last;
   logic [35:0] in_prod;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [20:0] out_data;
   logic        out_sat;
   logic [8:0]  out_count;
   logic        err_terms;

   int vectors;
   int miscompares;

   mpc_dot_accum dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_prod   (in_prod),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_count (out_count),
      .err_terms (err_terms)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
   task automatic send_beat(input logic [35:0] p, input logic l);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         n++;
         if (n > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout: in_ready stayed %b, required 1", in_ready);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b1;
      #3 reset = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
      vectors++; if (out_data !== 21'd0) begin miscompares++; $display("FAIL reset_data got %0d want 0", out_data); end
      vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat got %b want 0", out_sat); end
      vectors++; if (out_count !== 9'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", out_count); end
      vectors++; if (err_terms !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_terms); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      send_beat(36'd16384, 1'b0);
      send_beat(36'd16384, 1'b0);
      send_beat(36'd16384, 1'b1);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", out_valid); end
      vectors++; if (out_data !== 21'd3) begin miscompares++; $display("FAIL basic_data got %0d want 3", $signed(out_data)); end
      vectors++; if (out_count !== 9'd3) begin miscompares++; $display("FAIL basic_count got %0d want 3", out_count); end
      vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL basic_sat got %b want 0", out_sat); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain got %b want 0", out_valid); end
   endtask

   task automatic test_rounding;
      logic [35:0] prods [4];
      logic [20:0] exps  [4];
      prods[0] = 36'd8192;      exps[0] = 21'd1;
      prods[1] = 36'(-8192);    exps[1] = 21'd0;
      prods[2] = 36'(-8193);    exps[2] = 21'(-1);
      prods[3] = 36'd8191;      exps[3] = 21'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_beat(prods[i], 1'b1);
         vectors++; if (out_data !== exps[i]) begin miscompares++; $display("FAIL round_%0d_data got %0d want %0d", i, $signed(out_data), $signed(exps[i])); end
         vectors++; if (out_count !== 9'd1) begin miscompares++; $display("FAIL round_%0d_count got %0d want 1", i, out_count); end
         vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL round_%0d_sat got %b want 0", i, out_sat); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturation;
      out_ready = 1'b1;
      send_beat(36'h4_0000_0000, 1'b0);
      send_beat(36'h4_0000_0000, 1'b1);
      vectors++; if (out_data !== 21'd1048575) begin miscompares++; $display("FAIL satpos_data got %0d want 1048575", $signed(out_data)); end
      vectors++; if (out_sat !== 1'b1) begin miscompares++; $display("FAIL satpos_flag got %b want 1", out_sat); end
      send_beat(36'h8_0000_0000, 1'b0);
      send_beat(36'h8_0000_0000, 1'b1);
      vectors++; if (out_data !== 21'h10_0000) begin miscompares++; $display("FAIL satneg_data got %0d want -1048576", $signed(out_data)); end
      vectors++; if (out_sat !== 1'b1) begin miscompares++; $display("FAIL satneg_flag got %b want 1", out_sat); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      send_beat(36'd16384, 1'b1);
      vectors++; if (out_data !== 21'd1) begin miscompares++; $display("FAIL bp_a_data got %0d want 1", $signed(out_data)); end
      in_valid = 1'b1; in_prod = 36'd32768; in_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_%0d got %b want 0", i, in_ready); end
         vectors++; if (out_data !== 21'd1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_%0d got %0d/%b want 1/1", i, $signed(out_data), out_valid); end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_a_drain got %b want 0", out_valid); end
      send_beat(36'd16384, 1'b1);
      vectors++; if (out_data !== 21'd3) begin miscompares++; $display("FAIL bp_b_data got %0d want 3", $signed(out_data)); end
      vectors++; if (out_count !== 9'd2) begin miscompares++; $display("FAIL bp_b_count got %0d want 2", out_count); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_b_drain got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      send_beat(36'd16384, 1'b1);
      in_valid = 1'b1; in_prod = 36'd32768; in_last = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b want 1", out_valid); end
      vectors++; if (out_data !== 21'd2) begin miscompares++; $display("FAIL b2b_data got %0d want 2", $signed(out_data)); end
      vectors++; if (out_count !== 9'd1) begin miscompares++; $display("FAIL b2b_count got %0d want 1", out_count); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", out_valid); end
   endtask

   task automatic test_ce_stall;
      out_ready = 1'b1;
      send_beat(36'd16384, 1'b0);
      in_valid = 1'b1; in_prod = 36'd16384; in_last = 1'b0;
      ce = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_%0d got %b want 0", i, in_ready); end
      end
      @(posedge clk); #1;
      ce = 1'b1;
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_resume got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      send_beat(36'd16384, 1'b1);
      vectors++; if (out_data !== 21'd3) begin miscompares++; $display("FAIL stall_data got %0d want 3", $signed(out_data)); end
      vectors++; if (out_count !== 9'd3) begin miscompares++; $display("FAIL stall_count got %0d want 3", out_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_limit;
      out_ready = 1'b1;
      send_beat(36'd16384, 1'b0);
      send_beat(36'd16384, 1'b0);
      #2 reset = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got %b want 0", out_valid); end
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;
      send_beat(36'd16384, 1'b1);
      vectors++; if (out_data !== 21'd1) begin miscompares++; $display("FAIL midreset_data got %0d want 1", $signed(out_data)); end
      vectors++; if (out_count !== 9'd1) begin miscompares++; $display("FAIL midreset_count got %0d want 1", out_count); end
      for (int i = 0; i < 256; i++) send_beat(36'd1, 1'b0);
      vectors++; if (err_terms !== 1'b0) begin miscompares++; $display("FAIL limit_256 got %b want 0", err_terms); end
      send_beat(36'd1, 1'b0);
      vectors++; if (err_terms !== 1'b1) begin miscompares++; $display("FAIL limit_257 got %b want 1", err_terms); end
      send_beat(36'd1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (err_terms !== 1'b1) begin miscompares++; $display("FAIL limit_sticky got %b want 1", err_terms); end
      reset = 1'b0;
      #1;
      vectors++; if (err_terms !== 1'b0) begin miscompares++; $display("FAIL limit_clear got %b want 0", err_terms); end
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset;
      test_basic;
      test_rounding;
      test_saturation;
      test_backpressure;
      test_back_to_back;
      test_ce_stall;
      test_reset_limit;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
